spi_target_engine: RTL and testbench
====================================

# spi_target_engine

SPI mode-0 target (responder) byte engine, the counterpart of the housekeeping SPI initiator. It oversamples an external SCK/CSB/MOSI with the system clock, deserialises MOSI into bytes and serialises a queued byte onto MISO, MSB first. It sits between the housekeeping register logic and the chip-level SPI target pins, and presents a byte-level valid/ready interface to the logic side.

## Interface
- `FILL_BYTE`, default `8'hFF`: byte shifted out on MISO when no transmit byte is queued (underrun).
- `clk_i` in 1: system clock, must be ≥ 4× the SCK frequency.
- `reset_ni` in 1: reset, asynchronous and active-low. One clock domain (`clk_i`).
- `spi_sck_i` in 1: SPI clock from initiator, asynchronous to `clk_i`.
- `spi_csb_i` in 1: chip select, active-low, asynchronous.
- `spi_mosi_i` in 1: serial data in, asynchronous.
- `spi_miso_o` out 1: serial data out.
- `spi_miso_oe_o` out 1: MISO output enable; high while the synchronised CSB is low.
- `tx_data_i` in 8: next byte to transmit.
- `tx_valid_i` in 1: `tx_data_i` valid.
- `tx_ready_o` out 1: holding register empty; transfer occurs when `tx_valid_i && tx_ready_o`.
- `rx_data_o` out 8: last complete received byte; holds until the next byte completes.
- `rx_valid_o` out 1: one-cycle pulse when `rx_data_o` updates.
- `busy_o` out 1: frame active (synchronised CSB low).

## Operation
- Inputs pass through 2-flop synchronisers. The CSB synchroniser resets to 1; SCK and MOSI synchronisers reset to 0. A third flop on SCK and CSB provides edge detection.
- FSM states:
  - IDLE → ACTIVE on synchronised CSB falling edge.
  - ACTIVE → IDLE on synchronised CSB rising edge.
  - No other states.
- On CSB fall:
  - Load the TX shift register from the holding register if full (holding becomes empty), else from `FILL_BYTE`.
  - Drive `spi_miso_o` with bit 7 of the loaded byte.
  - Clear `bit_cnt` (3 bits).
- On SCK rise (ACTIVE only):
  - `rx_shift <= {rx_shift[6:0], mosi_sync}`.
  - `bit_cnt` increments and wraps 7→0.
  - When `bit_cnt` was 7, also set `rx_data_o <= {rx_shift[6:0], mosi_sync}` and pulse `rx_valid_o`.
- On SCK fall (ACTIVE only):
  - If `bit_cnt == 0`, a byte boundary has been reached: reload from holding or `FILL_BYTE` as at CSB fall, and drive its bit 7.
  - Otherwise, shift left and drive the next bit.
- Holding register: one entry. Written when `tx_valid_i && tx_ready_o`; `tx_ready_o = !full`.
- Boundary behaviour:
  - **Same-cycle write and load with holding empty:** the load takes `FILL_BYTE`; the written byte lands in holding for the next byte.
  - **Holding full:** `tx_valid_i` is ignored.
  - **CSB rise mid-byte:** the partial RX byte is discarded (no `rx_valid_o`), `bit_cnt` clears, and the unsent TX shift contents are dropped. The holding register is kept.
  - **SCK edges while IDLE:** ignored.
  - **`reset_ni` asserted mid-frame:** all state returns to reset values immediately.
  - **Unread RX data:** `rx_data_o` is overwritten by the next byte without error; the consumer must accept every `rx_valid_o` pulse.

## Timing
- Reset values:
  - `spi_miso_o` = 0, `spi_miso_oe_o` = 0
  - `tx_ready_o` = 1
  - `rx_data_o` = 8'h00, `rx_valid_o` = 0
  - `busy_o` = 0
  - FSM = IDLE
- Pin edge to internal action: 3 `clk_i` cycles (2 sync + 1 detect). Registered outputs update one cycle after that.
- `rx_valid_o` asserts 4 `clk_i` cycles after the 8th SCK rising edge at the pin.
- `spi_miso_o` changes ≤ 4 `clk_i` cycles after SCK fall or CSB fall. The first SCK rise must follow CSB fall by ≥ 5 `clk_i` cycles.
- `tx_ready_o` reasserts the cycle after the holding register is consumed.

## Configuration
- `SPI_TARGET_UNDERRUN_CNT_EN` defined:
  - Adds output `underrun_cnt_o` [7:0], an 8-bit saturating counter (reset 0, sticks at 255).
  - The counter increments on every load that uses `FILL_BYTE`.
  - A same-cycle `tx_valid_i` does not prevent the count.
- `SPI_TARGET_UNDERRUN_CNT_EN` undefined: no port and no counter logic. All other behaviour is identical.

## Test plan
- **Single-byte frame:** queue `8'hA5`, then a frame with MOSI = `8'h3C` at SCK = clk/8. Expect MISO bits 1,0,1,0,0,1,0,1; one `rx_valid_o` pulse with `rx_data_o = 8'h3C`; `tx_ready_o` high after the CSB fall.
- **Two-byte frame, second byte queued mid-frame:** queue `8'h12`, then `8'h34` during byte 0. Expect MISO `8'h12` then `8'h34`; two `rx_valid_o` pulses.
- **Underrun:** nothing queued; frame of 2 bytes. Expect MISO `8'hFF`, `8'hFF`. With the macro defined, `underrun_cnt_o` = 2.
- **CSB abort:** raise CSB after 5 SCK rising edges. Expect no `rx_valid_o` and `busy_o` low 3–4 cycles later. The next frame with MOSI = `8'h81` yields `rx_data_o = 8'h81`.
- **Reset mid-frame:** assert `reset_ni` low after 3 bits. Expect all outputs at reset values asynchronously, and a correct subsequent frame after release.
- **SCK activity with CSB high:** toggle SCK 16 times with CSB high. Expect no `rx_valid_o`, `spi_miso_oe_o` = 0, and the holding register unchanged.

Source files
------------

// File: rtl/spi_target_engine_if.sv
// Byte-level stream between the SPI target engine and the housekeeping logic.
// The slave modport is the engine side; the master modport is the logic side.
interface spi_target_engine_if;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;

  modport slave (
    input  tx_data_i,
    input  tx_valid_i,
    output tx_ready_o,
    output rx_data_o,
    output rx_valid_o
  );

  modport master (
    output tx_data_i,
    output tx_valid_i,
    input  tx_ready_o,
    input  rx_data_o,
    input  rx_valid_o
  );
endinterface

// File: rtl/spi_target_engine.sv
// SPI mode-0 target byte engine: oversampled SCK/CSB/MOSI, MSB-first RX/TX, one-entry TX holding register.
// Optional SPI_TARGET_UNDERRUN_CNT_EN adds a saturating count of FILL_BYTE loads on underrun_cnt_o.
module spi_target_engine #(
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                spi_sck_i,
  input  logic                spi_csb_i,
  input  logic                spi_mosi_i,
  output logic                spi_miso_o,
  output logic                spi_miso_oe_o,
  output logic                busy_o,
  spi_target_engine_if.slave  byte_if
`ifdef SPI_TARGET_UNDERRUN_CNT_EN
  ,
  output logic [7:0]          underrun_cnt_o
`endif
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e     state_q, state_d;

  logic [2:0] csb_sync_q;
  logic [2:0] sck_sync_q;
  logic [1:0] mosi_sync_q;

  // Bit 7 of the current byte lives in miso_q; tx_shift_q keeps the remaining bits.
  logic [6:0] tx_shift_q, tx_shift_d;
  logic       miso_q, miso_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
`ifdef SPI_TARGET_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt_q, underrun_cnt_d;
`endif

  logic       csb_fall, csb_rise, sck_rise, sck_fall, mosi_s;
  logic       frame_ok, load, hold_wr;
  logic [7:0] load_byte;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      csb_sync_q  <= 3'b111;
      sck_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      csb_sync_q  <= {csb_sync_q[1:0], spi_csb_i};
      sck_sync_q  <= {sck_sync_q[1:0], spi_sck_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
    end
  end

  assign csb_fall = csb_sync_q[2] & ~csb_sync_q[1];
  assign csb_rise = ~csb_sync_q[2] & csb_sync_q[1];
  assign sck_rise = ~sck_sync_q[2] & sck_sync_q[1];
  assign sck_fall = sck_sync_q[2] & ~sck_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];

  // A CSB rise wins over any SCK edge in the same cycle so the partial byte is dropped cleanly.
  assign frame_ok  = (state_q == ST_ACTIVE) && !csb_rise;
  assign load      = ((state_q == ST_IDLE) && csb_fall) ||
                     (frame_ok && sck_fall && (bit_cnt_q == 3'd0));
  assign load_byte = hold_full_q ? hold_q : FILL_BYTE;
  assign hold_wr   = byte_if.tx_valid_i && !hold_full_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (csb_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (csb_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`ifdef SPI_TARGET_UNDERRUN_CNT_EN
    underrun_cnt_d = underrun_cnt_q;
    if (load && !hold_full_q && (underrun_cnt_q != 8'hFF)) begin
      underrun_cnt_d = underrun_cnt_q + 8'd1;
    end
`endif

    if (load) begin
      tx_shift_d = load_byte[6:0];
      miso_d     = load_byte[7];
      if (hold_full_q) hold_full_d = 1'b0;
    end else if (frame_ok && sck_fall) begin
      tx_shift_d = {tx_shift_q[5:0], 1'b0};
      miso_d     = tx_shift_q[6];
    end

    if ((state_q == ST_IDLE) && csb_fall) begin
      bit_cnt_d = 3'd0;
    end

    if (frame_ok && sck_rise) begin
      rx_shift_d = {rx_shift_q[5:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d  = {rx_shift_q, mosi_s};
        rx_valid_d = 1'b1;
      end
    end

    if ((state_q == ST_ACTIVE) && csb_rise) begin
      bit_cnt_d  = 3'd0;
      tx_shift_d = 7'd0;
      miso_d     = 1'b0;
      rx_shift_d = 7'd0;
    end

    // Writes only happen while empty and loads only consume while full, so they never collide.
    if (hold_wr) begin
      hold_d      = byte_if.tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      tx_shift_q  <= 7'd0;
      miso_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

`ifdef SPI_TARGET_UNDERRUN_CNT_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) underrun_cnt_q <= 8'd0;
    else           underrun_cnt_q <= underrun_cnt_d;
  end

  assign underrun_cnt_o = underrun_cnt_q;
`endif

  assign spi_miso_o         = miso_q;
  assign spi_miso_oe_o      = (state_q == ST_ACTIVE);
  assign busy_o             = (state_q == ST_ACTIVE);
  assign byte_if.tx_ready_o = !hold_full_q;
  assign byte_if.rx_data_o  = rx_data_q;
  assign byte_if.rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_target_engine.sv
// Directed bench for spi_target_engine: an SPI mode-0 initiator at SCK = clk/8 plus byte-side stimulus.
module tb_spi_target_engine;
  logic clk = 1'b0;
  logic reset_n;
  logic sck, csb, mosi;
  logic miso, miso_oe, busy;
`ifdef SPI_TARGET_UNDERRUN_CNT_EN
  logic [7:0] ucnt;
`endif

  int total = 0;
  int bad   = 0;
  int rx_cnt = 0;
  logic [7:0] rx_last = 8'h00;

  spi_target_engine_if u_if ();

  spi_target_engine #(.FILL_BYTE(8'hFF)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .spi_sck_i      (sck),
    .spi_csb_i      (csb),
    .spi_mosi_i     (mosi),
    .spi_miso_o     (miso),
    .spi_miso_oe_o  (miso_oe),
    .busy_o         (busy),
    .byte_if        (u_if.slave)
`ifdef SPI_TARGET_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (ucnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.rx_valid_o === 1'b1) begin
      rx_cnt  <= rx_cnt + 1;
      rx_last <= u_if.rx_data_o;
    end
  end

  task automatic queue_tx(input logic [7:0] d, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    u_if.tx_data_i  = d;
    u_if.tx_valid_i = 1'b1;
    while (u_if.tx_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (u_if.tx_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s_queue: tx_ready=%b required=1 within 50 cycles", nm, u_if.tx_ready_o);
    end
    @(negedge clk);
    u_if.tx_valid_i = 1'b0;
  endtask

  task automatic frame_start();
    @(negedge clk);
    csb = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // SCK is left high after the final bit; frame_end raises CSB before SCK returns low.
  task automatic xfer_byte(input logic [7:0] mo, input bit last, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      repeat (4) @(negedge clk);
      mi[i] = miso;
      sck = 1'b1;
      repeat (4) @(negedge clk);
      if (!(last && i == 0)) sck = 1'b0;
    end
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    csb = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sck = 1'b0; csb = 1'b1; mosi = 1'b0;
    u_if.tx_data_i = 8'h00; u_if.tx_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got=%b exp=0", miso); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got=%b exp=0", miso_oe); end
    total++; if (u_if.tx_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got=%b exp=1", u_if.tx_ready_o); end
    total++; if (u_if.rx_data_o !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got=%h exp=00", u_if.rx_data_o); end
    total++; if (u_if.rx_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got=%b exp=0", u_if.rx_valid_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", busy); end
`ifdef SPI_TARGET_UNDERRUN_CNT_EN
    total++; if (ucnt !== 8'd0) begin bad++; $display("FAIL reset_ucnt: got=%0d exp=0", ucnt); end
`endif
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single_byte();
    logic [7:0] mi;
    int base;
    queue_tx(8'hA5, "single");
    total++; if (u_if.tx_ready_o !== 1'b0) begin bad++; $display("FAIL single_ready_full: got=%b exp=0", u_if.tx_ready_o); end
    base = rx_cnt;
    frame_start();
    total++; if (u_if.tx_ready_o !== 1'b1) begin bad++; $display("FAIL single_ready_after_fall: got=%b exp=1", u_if.tx_ready_o); end
    total++; if (busy !== 1'b1 || miso_oe !== 1'b1) begin bad++; $display("FAIL single_busy_oe: got=%b%b exp=11", busy, miso_oe); end
    xfer_byte(8'h3C, 1'b1, mi);
    frame_end();
    total++; if (mi !== 8'hA5) begin bad++; $display("FAIL single_miso: got=%h exp=a5", mi); end
    total++; if (rx_cnt - base != 1) begin bad++; $display("FAIL single_rx_pulses: got=%0d exp=1", rx_cnt - base); end
    total++; if (rx_last !== 8'h3C) begin bad++; $display("FAIL single_rx_data: got=%h exp=3c", rx_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got=%b exp=0", busy); end
    $display("test_single_byte miso=%h rx=%h", mi, rx_last);
  endtask

  task automatic test_two_byte();
    logic [7:0] m0, m1;
    int base;
    queue_tx(8'h12, "two");
    base = rx_cnt;
    frame_start();
    queue_tx(8'h34, "two_mid");
    xfer_byte(8'h55, 1'b0, m0);
    xfer_byte(8'hAA, 1'b1, m1);
    frame_end();
    total++; if (m0 !== 8'h12) begin bad++; $display("FAIL two_miso0: got=%h exp=12", m0); end
    total++; if (m1 !== 8'h34) begin bad++; $display("FAIL two_miso1: got=%h exp=34", m1); end
    total++; if (rx_cnt - base != 2) begin bad++; $display("FAIL two_rx_pulses: got=%0d exp=2", rx_cnt - base); end
    total++; if (rx_last !== 8'hAA) begin bad++; $display("FAIL two_rx_data: got=%h exp=aa", rx_last); end
    $display("test_two_byte miso=%h %h rx=%h", m0, m1, rx_last);
  endtask

  task automatic test_underrun();
    logic [7:0] m0, m1;
    int base;
`ifdef SPI_TARGET_UNDERRUN_CNT_EN
    logic [7:0] c0;
    c0 = ucnt;
`endif
    base = rx_cnt;
    frame_start();
    xfer_byte(8'h01, 1'b0, m0);
    xfer_byte(8'h02, 1'b1, m1);
    frame_end();
    total++; if (m0 !== 8'hFF) begin bad++; $display("FAIL underrun_miso0: got=%h exp=ff", m0); end
    total++; if (m1 !== 8'hFF) begin bad++; $display("FAIL underrun_miso1: got=%h exp=ff", m1); end
    total++; if (rx_cnt - base != 2) begin bad++; $display("FAIL underrun_rx_pulses: got=%0d exp=2", rx_cnt - base); end
`ifdef SPI_TARGET_UNDERRUN_CNT_EN
    total++; if (ucnt - c0 !== 8'd2) begin bad++; $display("FAIL underrun_cnt: got=%0d exp=%0d", ucnt, c0 + 8'd2); end
`endif
    $display("test_underrun miso=%h %h", m0, m1);
  endtask

  task automatic test_csb_abort();
    logic [7:0] mi;
    int base, n;
    base = rx_cnt;
    frame_start();
    queue_tx(8'h77, "abort");
    for (int i = 0; i < 5; i++) begin
      mosi = i[0];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (2) @(negedge clk);
    csb = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy === 1'b0) break;
    end
    total++; if (n < 3 || n > 4) begin bad++; $display("FAIL abort_busy_latency: got=%0d cycles exp=3..4", n); end
    repeat (8) @(negedge clk);
    total++; if (rx_cnt - base != 0) begin bad++; $display("FAIL abort_rx_pulses: got=%0d exp=0", rx_cnt - base); end
    total++; if (u_if.tx_ready_o !== 1'b0) begin bad++; $display("FAIL abort_hold_kept: ready=%b exp=0", u_if.tx_ready_o); end
    frame_start();
    xfer_byte(8'h81, 1'b1, mi);
    frame_end();
    total++; if (mi !== 8'h77) begin bad++; $display("FAIL abort_next_miso: got=%h exp=77", mi); end
    total++; if (rx_cnt - base != 1 || rx_last !== 8'h81) begin bad++; $display("FAIL abort_next_rx: got=%h n=%0d exp=81 n=1", rx_last, rx_cnt - base); end
    $display("test_csb_abort latency=%0d next_rx=%h", n, rx_last);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] mi;
    int base;
    queue_tx(8'h5A, "rst");
    frame_start();
    queue_tx(8'h66, "rst_hold");
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL rstmid_miso: got=%b exp=0", miso); end
    total++; if (miso_oe !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_oe_busy: got=%b%b exp=00", miso_oe, busy); end
    total++; if (u_if.tx_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got=%b exp=1", u_if.tx_ready_o); end
    total++; if (u_if.rx_data_o !== 8'h00 || u_if.rx_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_rx: got=%h/%b exp=00/0", u_if.rx_data_o, u_if.rx_valid_o); end
`ifdef SPI_TARGET_UNDERRUN_CNT_EN
    total++; if (ucnt !== 8'd0) begin bad++; $display("FAIL rstmid_ucnt: got=%0d exp=0", ucnt); end
`endif
    csb = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    base = rx_cnt;
    queue_tx(8'hC3, "rst_after");
    frame_start();
    xfer_byte(8'h96, 1'b1, mi);
    frame_end();
    total++; if (mi !== 8'hC3) begin bad++; $display("FAIL rstmid_next_miso: got=%h exp=c3", mi); end
    total++; if (rx_cnt - base != 1 || rx_last !== 8'h96) begin bad++; $display("FAIL rstmid_next_rx: got=%h n=%0d exp=96 n=1", rx_last, rx_cnt - base); end
    $display("test_reset_mid_frame miso=%h rx=%h", mi, rx_last);
  endtask

  task automatic test_sck_idle();
    logic [7:0] mi;
    int base;
    bit oe_seen;
    queue_tx(8'hE1, "idle");
    base = rx_cnt;
    oe_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sck = ~sck;
      mosi = i[1];
      repeat (2) @(negedge clk);
      if (miso_oe !== 1'b0) oe_seen = 1'b1;
    end
    repeat (4) @(negedge clk);
    total++; if (oe_seen) begin bad++; $display("FAIL idle_oe: got=1 exp=0"); end
    total++; if (rx_cnt - base != 0) begin bad++; $display("FAIL idle_rx_pulses: got=%0d exp=0", rx_cnt - base); end
    u_if.tx_data_i = 8'h99; u_if.tx_valid_i = 1'b1;
    repeat (4) @(negedge clk);
    u_if.tx_valid_i = 1'b0;
    total++; if (u_if.tx_ready_o !== 1'b0) begin bad++; $display("FAIL idle_hold_full: ready=%b exp=0", u_if.tx_ready_o); end
    frame_start();
    xfer_byte(8'h0F, 1'b1, mi);
    frame_end();
    total++; if (mi !== 8'hE1) begin bad++; $display("FAIL idle_hold_miso: got=%h exp=e1", mi); end
    total++; if (rx_last !== 8'h0F) begin bad++; $display("FAIL idle_next_rx: got=%h exp=0f", rx_last); end
    $display("test_sck_idle miso=%h rx=%h", mi, rx_last);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_byte();
    test_underrun();
    test_csb_abort();
    test_reset_mid_frame();
    test_sck_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
